hls_saturation_mul_arbiter: RTL and testbench
=============================================

# hls_saturation_mul_arbiter

Round-robin scheduler that shares one 16x8 unsigned multiplier (the saturation-enhance gain multiply) between `NUM_REQ` requesters, typically the R/G/B channel paths of the saturation core. Accepts operand pairs over valid/ready handshakes and runs them through a `PIPE_STAGES`-deep stallable pipeline. Returns each 24-bit product tagged with the originating requester ID on a single result bus with backpressure. Sits between the per-channel pixel datapaths and the saturation output stage.

## Interface
- `NUM_REQ`, 3: number of requesters, 2..8.
- `PIPE_STAGES`, 2: total latency from accept to result, 1..4; the multiply sits in stage 1.
- `ID_W`, 3: width of the result tag; must satisfy 2^`ID_W` >= `NUM_REQ`.

- `ap_clk`  in  1  clock; all logic on the rising edge.
- `ap_rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  `NUM_REQ`  per-requester operand valid.
- `req_ready`  out  `NUM_REQ`  per-requester accept strobe; at most one bit high per cycle.
- `req_a`  in  16*`NUM_REQ`  operand A (pixel term), requester i at bits [16i+15:16i].
- `req_b`  in  8*`NUM_REQ`  operand B (gain), requester i at bits [8i+7:8i].
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result consumer ready.
- `res_id`  out  `ID_W`  requester index of the current result.
- `res_data`  out  24  product (see Configuration).
- `busy`  out  1  high while any pipeline stage holds a valid entry.

## Operation
- Pipeline advance: `adv = !res_valid || res_ready`. When `adv` = 0, every stage, `res_*` and the round-robin pointer hold, and all `req_ready` bits are 0.
- Arbitration: round-robin pointer `ptr`, reset to 0. While `adv` = 1, grant goes to the first i with `req_valid[i]` = 1, searching from `ptr` upward and wrapping modulo `NUM_REQ`. `req_ready[i]` is high for the granted requester only. This ready path is combinational from `req_valid` and `adv`.
- Pointer update: on a transfer (`req_valid[g]` && `req_ready[g]`), `ptr` becomes (g+1) mod `NUM_REQ`. With no transfer, `ptr` holds.
- Issue: the granted operands and ID are registered into stage 0 with valid=1. If nothing is granted while `adv` = 1, a bubble (valid=0) enters.
- Stage 1 registers `a*b` as a full 24-bit unsigned product. There is no truncation: 0xFFFF*0xFF = 0xFEFF01.
- Remaining stages carry the product and ID unchanged. The last stage drives `res_valid`/`res_id`/`res_data`.
- A result transfers when `res_valid` && `res_ready`. `res_data`/`res_id` are stable while `res_valid` is high and `res_ready` is low.
- Results leave in acceptance order, one per requester transfer, never duplicated or dropped.
- Reset mid-operation: all in-flight entries are discarded with no result emitted, and `ptr` returns to 0.

## Timing
- Reset values: `req_ready`=0 during `ap_rst`, `res_valid`=0, `res_id`=0, `res_data`=0, `busy`=0, `ptr`=0, all stage valid bits 0.
- Latency: an operand accepted in cycle T produces `res_valid`=1 in cycle T+`PIPE_STAGES`, given `res_ready` was held high.
- Throughput: one accept per cycle sustained while `res_ready`=1.
- Backpressure: each stall cycle adds exactly one cycle to the latency of every in-flight entry.
- Simultaneous `res_ready` rise and new request: the result transfer and the new accept happen in the same cycle.
- The first cycle after `ap_rst` deasserts may accept a request.
- `busy` is the OR of the stage valid bits, registered-state only, with no combinational path from inputs.

## Configuration
- `HLS_SAT_ARB_SATURATE_EN` defined:
  - the output stage applies the Q1.7 gain scaling `res_data = min(p >> 7, 0x00FFFF)`, so `res_data[23:16]` is always 0;
  - the extra logic is combinational inside the last stage, so latency is unchanged.
- Undefined: `res_data` is the raw 24-bit product.

## Test plan
- Single requester: `req_valid[0]`=1, a=0x1234, b=0x02, `res_ready`=1 → `req_ready[0]`=1 at T; `res_valid`=1 at T+2, id=0, data=0x002468 (macro undefined).
- Three simultaneous requests (a=1,2,3; b=0x10) held continuously → accepts go 0,1,2,0,… on consecutive cycles; results ids 0,1,2 at T+2,T+3,T+4 with data 0x10,0x20,0x30.
- Backpressure: hold `res_ready`=0 for 5 cycles with a result pending → `req_ready`=0 and `res_data`/`res_id` stable throughout; after release, all queued results drain in order with no loss.
- Max operands: a=0xFFFF, b=0xFF → 0xFEFF01 with the macro undefined; 0x00FFFF with `HLS_SAT_ARB_SATURATE_EN` defined. Also a=0x1000, b=0x80 → 0x080000 undefined, 0x001000 defined.
- Reset mid-flight: accept two requests, then assert `ap_rst` for one cycle before any result → no `res_valid` afterwards, `busy`=0, next grant starts from requester 0.
- Fairness: requester 1 constantly valid, requester 2 raises valid → requester 2 granted no later than the second accept after its raise.

Source files
------------

// File: rtl/hls_saturation_mul_arbiter.sv
// hls_saturation_mul_arbiter
//
// Purpose:
//   Shares one 16x8 unsigned multiplier (the saturation-enhance gain multiply)
//   between NUM_REQ requesters. A round-robin arbiter picks one requester per
//   cycle. Its operands go through a PIPE_STAGES-deep pipeline that stalls as
//   a whole. The 24-bit product comes out on one result bus with backpressure,
//   tagged with the ID of the requester that sent the operands.
//
// Parameters:
//   NUM_REQ     - number of requesters (2..8)
//   PIPE_STAGES - latency from accept to result (1..4); multiply in stage 1
//   ID_W        - result tag width, 2**ID_W >= NUM_REQ
//
// Ports:
//   ap_clk     in   clock, rising edge
//   ap_rst     in   synchronous active-high reset
//   req_valid  in   [NUM_REQ]      per-requester operand valid
//   req_ready  out  [NUM_REQ]      per-requester accept strobe (one-hot or zero)
//   req_a      in   [16*NUM_REQ]   operand A, requester i at [16i+15:16i]
//   req_b      in   [8*NUM_REQ]    operand B, requester i at [8i+7:8i]
//   res_valid  out  result valid
//   res_ready  in   result consumer ready
//   res_id     out  [ID_W]         requester index of the current result
//   res_data   out  [24]           product (optionally scaled and saturated)
//   busy       out  high while any pipeline stage holds a valid entry
//
// Configuration macro:
//   HLS_SAT_ARB_SATURATE_EN - when defined, the output applies Q1.7 gain
//   scaling, res_data = min(product >> 7, 0x00FFFF). This logic is purely
//   combinational on the last stage, so the latency does not change.

module hls_saturation_mul_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int PIPE_STAGES = 2,
  parameter int ID_W        = 3
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0]  req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ID_W-1:0]       res_id,
  output logic [23:0]           res_data,
  output logic                  busy
);

  localparam int LAST = PIPE_STAGES - 1;

  // With a single stage, the product has to be formed on the way into
  // stage 0. Otherwise stage 0 holds the raw operands and stage 1 multiplies.
  localparam bit MUL_AT_ISSUE = (PIPE_STAGES == 1);

  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [PIPE_STAGES-1:0] vld_q, vld_d;
  logic [ID_W-1:0]        id_q   [PIPE_STAGES];
  logic [ID_W-1:0]        id_d   [PIPE_STAGES];
  logic [23:0]            data_q [PIPE_STAGES];
  logic [23:0]            data_d [PIPE_STAGES];

  logic                   adv;
  logic                   grant_any;
  logic [ID_W-1:0]        grant_idx;
  logic                   xfer;
  logic [15:0]            sel_a;
  logic [7:0]             sel_b;

  // The whole pipeline moves only when the output slot is empty or is being
  // drained this cycle.
  assign res_valid = vld_q[LAST];
  assign res_id    = id_q[LAST];
  assign adv       = !res_valid || res_ready;
  assign busy      = |vld_q;

  // Round-robin search. Priority position k maps to requester (ptr+k) mod N.
  // The loops compare ptr against constants, so no requester is selected
  // through a variable index.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && req_valid[i] &&
            (ptr_q == ID_W'((i - k + NUM_REQ) % NUM_REQ))) begin
          grant_any = 1'b1;
          grant_idx = ID_W'(i);
        end
      end
    end
  end

  // The ready strobe is masked by reset and by a stalled pipeline. A transfer
  // therefore happens exactly when a grant exists and the pipeline can take it.
  always_comb begin
    xfer  = adv && !ap_rst && grant_any;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = xfer && (grant_idx == ID_W'(i));
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[16*i +: 16];
        sel_b = req_b[8*i +: 8];
      end
    end
  end

  // After a transfer, the pointer moves one past the winner so that the
  // winner becomes lowest priority. It holds when nothing transfers.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      if (grant_idx == ID_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + ID_W'(1);
      end
    end
  end

  // Next-state of the pipeline. Stage 0 packs {b, a} into its 24-bit data
  // slot, which is exactly wide enough. Stage 1 replaces that with the full
  // product. Later stages copy it unchanged. When the pipeline stalls,
  // everything holds.
  always_comb begin
    vld_d = vld_q;
    for (int s = 0; s < PIPE_STAGES; s++) begin
      id_d[s]   = id_q[s];
      data_d[s] = data_q[s];
    end
    if (adv) begin
      vld_d[0] = xfer;
      id_d[0]  = grant_idx;
      if (MUL_AT_ISSUE) begin
        data_d[0] = 24'(sel_a) * 24'(sel_b);
      end else begin
        data_d[0] = {sel_b, sel_a};
      end
      for (int s = 1; s < PIPE_STAGES; s++) begin
        vld_d[s] = vld_q[s-1];
        id_d[s]  = id_q[s-1];
        if (s == 1) begin
          data_d[s] = 24'(data_q[0][15:0]) * 24'(data_q[0][23:16]);
        end else begin
          data_d[s] = data_q[s-1];
        end
      end
    end
  end

  // State registers. Reset drops every in-flight entry and rewinds the
  // pointer to requester 0.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ptr_q <= '0;
      vld_q <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        id_q[s]   <= '0;
        data_q[s] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        id_q[s]   <= id_d[s];
        data_q[s] <= data_d[s];
      end
    end
  end

`ifdef HLS_SAT_ARB_SATURATE_EN
  // Q1.7 gain: drop the 7 fractional bits and clamp to 16 bits.
  logic [23:0] scaled;

  always_comb begin
    scaled = data_q[LAST] >> 7;
    if (scaled > 24'h00FFFF) begin
      res_data = 24'h00FFFF;
    end else begin
      res_data = scaled;
    end
  end
`else
  // Raw full-width product.
  assign res_data = data_q[LAST];
`endif

endmodule

// File: tb/tb_hls_saturation_mul_arbiter.sv
// Directed testbench for hls_saturation_mul_arbiter using the default
// parameters (3 requesters, 2 stages). Inputs change 1 ns after each rising
// edge. Outputs are checked 5 ns after the edge, which is mid-cycle.

module tb_hls_saturation_mul_arbiter;

  logic        ap_clk;
  logic        ap_rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [47:0] req_a;
  logic [23:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  res_id;
  logic [23:0] res_data;
  logic        busy;

  int vectors;
  int miscompares;

  logic [2:0]  expReady;
  logic [23:0] expMax;
  logic [23:0] expHalf;
  logic [2:0]  fairReady [6];
  logic [2:0]  fairId    [6];

  hls_saturation_mul_arbiter #(
    .NUM_REQ(3),
    .PIPE_STAGES(2),
    .ID_W(3)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_id   (res_id),
    .res_data (res_data),
    .busy     (busy)
  );

  // Free-running 10 ns clock.
  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  // Move to the next cycle, drive the inputs, then wait until mid-cycle.
  task automatic applyStimulus(input logic rst, input logic [2:0] valid, input logic rdy);
    @(posedge ap_clk);
    #1;
    ap_rst    = rst;
    req_valid = valid;
    res_ready = rdy;
    #4;
  endtask

  // Compare one observed value against the value the bench computed.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic setOperands(input int i, input logic [15:0] a, input logic [7:0] b);
    req_a[16*i +: 16] = a;
    req_b[8*i +: 8]   = b;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ap_rst      = 1'b1;
    req_valid   = '0;
    res_ready   = 1'b1;
    req_a       = '0;
    req_b       = '0;

`ifdef HLS_SAT_ARB_SATURATE_EN
    expMax  = 24'h00FFFF;
    expHalf = 24'h001000;
`else
    expMax  = 24'hFEFF01;
    expHalf = 24'h080000;
`endif

    // Reset values, with a request pending to show that ready is masked.
    $display("[TB] reset state");
    applyStimulus(1'b1, 3'b001, 1'b1);
    applyStimulus(1'b1, 3'b001, 1'b1);
    checkOutput("rst_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'h0);
    checkOutput("rst_res_id", 32'(res_id), 32'h0);
    checkOutput("rst_res_data", 32'(res_data), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);

    // Single request accepted in the first cycle after reset, 2-cycle latency.
    $display("[TB] single requester");
    setOperands(0, 16'h1234, 8'h02);
    applyStimulus(1'b0, 3'b001, 1'b1);
    checkOutput("single_ready", 32'(req_ready), 32'h1);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("single_t1_valid", 32'(res_valid), 32'h0);
    checkOutput("single_t1_busy", 32'(busy), 32'h1);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("single_t2_valid", 32'(res_valid), 32'h1);
    checkOutput("single_t2_id", 32'(res_id), 32'h0);
    checkOutput("single_t2_data", 32'(res_data), 32'h002468);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("single_t3_valid", 32'(res_valid), 32'h0);
    checkOutput("single_t3_busy", 32'(busy), 32'h0);

    // Rewind the pointer, then hold three requests for four cycles.
    $display("[TB] round robin");
    applyStimulus(1'b1, 3'b000, 1'b1);
    setOperands(0, 16'h0001, 8'h10);
    setOperands(1, 16'h0002, 8'h10);
    setOperands(2, 16'h0003, 8'h10);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, (c < 4) ? 3'b111 : 3'b000, 1'b1);
      expReady = (c < 4) ? (3'b001 << (c % 3)) : 3'b000;
      checkOutput("rr_ready", 32'(req_ready), 32'(expReady));
      if (c >= 2) begin
        checkOutput("rr_valid", 32'(res_valid), 32'h1);
        checkOutput("rr_id", 32'(res_id), 32'((c - 2) % 3));
        checkOutput("rr_data", 32'(res_data), 32'(((c - 2) % 3 + 1) * 16));
      end
    end

    // Backpressure. The pointer now sits at 1. Accept 1 then 2, stall for
    // 5 cycles while requester 0 waits, then drain.
    $display("[TB] backpressure");
    applyStimulus(1'b0, 3'b010, 1'b1);
    checkOutput("bp_acc1", 32'(req_ready), 32'h2);
    applyStimulus(1'b0, 3'b100, 1'b1);
    checkOutput("bp_acc2", 32'(req_ready), 32'h4);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 3'b001, 1'b0);
      checkOutput("bp_stall_ready", 32'(req_ready), 32'h0);
      checkOutput("bp_stall_valid", 32'(res_valid), 32'h1);
      checkOutput("bp_stall_id", 32'(res_id), 32'h1);
      checkOutput("bp_stall_data", 32'(res_data), 32'h20);
    end
    applyStimulus(1'b0, 3'b001, 1'b1);
    checkOutput("bp_rel_ready", 32'(req_ready), 32'h1);
    checkOutput("bp_rel_id", 32'(res_id), 32'h1);
    checkOutput("bp_rel_data", 32'(res_data), 32'h20);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("bp_d1_valid", 32'(res_valid), 32'h1);
    checkOutput("bp_d1_id", 32'(res_id), 32'h2);
    checkOutput("bp_d1_data", 32'(res_data), 32'h30);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("bp_d2_valid", 32'(res_valid), 32'h1);
    checkOutput("bp_d2_id", 32'(res_id), 32'h0);
    checkOutput("bp_d2_data", 32'(res_data), 32'h10);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("bp_end_valid", 32'(res_valid), 32'h0);
    checkOutput("bp_end_busy", 32'(busy), 32'h0);

    // Operand extremes. The pointer is at 1 again.
    $display("[TB] max operands");
    setOperands(1, 16'hFFFF, 8'hFF);
    setOperands(2, 16'h1000, 8'h80);
    applyStimulus(1'b0, 3'b010, 1'b1);
    checkOutput("max_acc1", 32'(req_ready), 32'h2);
    applyStimulus(1'b0, 3'b100, 1'b1);
    checkOutput("max_acc2", 32'(req_ready), 32'h4);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("max_id", 32'(res_id), 32'h1);
    checkOutput("max_data", 32'(res_data), 32'(expMax));
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("half_id", 32'(res_id), 32'h2);
    checkOutput("half_data", 32'(res_data), 32'(expHalf));

    // Reset while two entries are in flight. The pointer is at 0.
    $display("[TB] reset mid-flight");
    setOperands(1, 16'h0002, 8'h10);
    setOperands(2, 16'h0003, 8'h10);
    applyStimulus(1'b0, 3'b001, 1'b1);
    checkOutput("mr_acc0", 32'(req_ready), 32'h1);
    applyStimulus(1'b0, 3'b010, 1'b1);
    checkOutput("mr_acc1", 32'(req_ready), 32'h2);
    applyStimulus(1'b1, 3'b000, 1'b0);
    applyStimulus(1'b0, 3'b111, 1'b1);
    checkOutput("mr_valid", 32'(res_valid), 32'h0);
    checkOutput("mr_busy", 32'(busy), 32'h0);
    checkOutput("mr_grant", 32'(req_ready), 32'h1);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("mr_t1_valid", 32'(res_valid), 32'h0);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("mr_t2_valid", 32'(res_valid), 32'h1);
    checkOutput("mr_t2_id", 32'(res_id), 32'h0);
    checkOutput("mr_t2_data", 32'(res_data), 32'h10);

    // Fairness. Requester 1 stays valid and requester 2 joins later.
    // The pointer is at 1.
    $display("[TB] fairness");
    fairReady = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b000, 3'b000};
    fairId    = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd2};
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, (c == 0) ? 3'b010 : ((c < 4) ? 3'b110 : 3'b000), 1'b1);
      checkOutput("fair_ready", 32'(req_ready), 32'(fairReady[c]));
      if (c >= 2) begin
        checkOutput("fair_valid", 32'(res_valid), 32'h1);
        checkOutput("fair_id", 32'(res_id), 32'(fairId[c]));
      end
    end
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("fair_end_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
